// File: rtl/ram_pkg.sv
// ram_pkg: shared FMI RAM geometry and reader types.
package ram_pkg;
    localparam int FMI_N_ELEM = 256;
    localparam int PX_W       = 16;
    localparam int FMI_AW     = $clog2(FMI_N_ELEM);

    typedef logic [PX_W-1:0] px_t;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} fmi_rd_state_t;
endpackage

// File: rtl/px_skid_fifo.sv
// px_skid_fifo: 2-entry FIFO of pixels with a last-pixel tag, absorbing stream back-pressure.
module px_skid_fifo
    import ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  px_t        push_data_i,
    input  logic       push_last_i,
    input  logic       pop_i,
    output px_t        head_data_o,
    output logic       head_last_o,
    output logic [1:0] count_o
);
    px_t        data_q [2];
    logic [1:0] last_q;
    logic       wr_q, rd_q;
    logic [1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (push_i) begin
                data_q[wr_q] <= push_data_i;
                last_q[wr_q] <= push_last_i;
                wr_q         <= ~wr_q;
            end
            if (pop_i) rd_q <= ~rd_q;
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign head_data_o = data_q[rd_q];
    assign head_last_o = last_q[rd_q];
    assign count_o     = cnt_q;
endmodule

// File: rtl/fmi_reader.sv
// fmi_reader: scans a rectangular tile out of the FMI RAM in row-major order onto a valid/ready stream,
// hiding the one-cycle RAM read latency behind a 2-entry skid FIFO.
module fmi_reader
    import ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [FMI_AW-1:0] base,
    input  logic [FMI_AW-1:0] n_rows,
    input  logic [FMI_AW-1:0] n_cols,
    input  logic [FMI_AW-1:0] stride,
    output logic [FMI_AW-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [PX_W-1:0]   ram_res,
    output logic [PX_W-1:0]   px_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              px_last,
    output logic              busy,
    output logic              done
);
    fmi_rd_state_t     state_q, state_d;
    logic [FMI_AW-1:0] row_base_q, row_base_d, row_q, row_d, col_q, col_d;
    logic [FMI_AW-1:0] n_rows_q, n_rows_d, n_cols_q, n_cols_d, stride_q, stride_d;
    logic              inflight_q, tag_q, done_q, done_d;
    logic [1:0]        fifo_cnt;
    px_t               head;
    logic              head_last, pop, is_last, can_issue;

    px_skid_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (inflight_q),
        .push_data_i(ram_res),
        .push_last_i(tag_q),
        .pop_i      (pop),
        .head_data_o(head),
        .head_last_o(head_last),
        .count_o    (fifo_cnt)
    );

    assign px_valid  = fifo_cnt != 2'd0;
    assign pop       = px_valid & px_ready;
    assign px_last   = px_valid & head_last;
    assign px_data   = head;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign ram_addr  = row_base_q + col_q;
    assign is_last   = (row_q == n_rows_q - FMI_AW'(1)) && (col_q == n_cols_q - FMI_AW'(1));
    // Occupancy after this cycle's pop must leave room for the read being issued.
    assign can_issue = ({1'b0, fifo_cnt} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});
    assign ram_rd    = (state_q == READ) && can_issue;

    always_comb begin
        state_d    = state_q;
        row_base_d = row_base_q;
        row_d      = row_q;
        col_d      = col_q;
        n_rows_d   = n_rows_q;
        n_cols_d   = n_cols_q;
        stride_d   = stride_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (n_rows == '0 || n_cols == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d    = READ;
                    row_base_d = base;
                    row_d      = '0;
                    col_d      = '0;
                    n_rows_d   = n_rows;
                    n_cols_d   = n_cols;
                    stride_d   = stride;
                end
            end
            READ: if (ram_rd) begin
                if (is_last) begin
                    state_d = DRAIN;
                end else if (col_q == n_cols_q - FMI_AW'(1)) begin
                    col_d      = '0;
                    row_d      = row_q + FMI_AW'(1);
                    row_base_d = row_base_q + stride_q;
                end else begin
                    col_d = col_q + FMI_AW'(1);
                end
            end
            DRAIN: if (pop && px_last) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_base_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            n_rows_q   <= '0;
            n_cols_q   <= '0;
            stride_q   <= '0;
            inflight_q <= 1'b0;
            tag_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_base_q <= row_base_d;
            row_q      <= row_d;
            col_q      <= col_d;
            n_rows_q   <= n_rows_d;
            n_cols_q   <= n_cols_d;
            stride_q   <= stride_d;
            inflight_q <= ram_rd;
            tag_q      <= ram_rd & is_last;
            done_q     <= done_d;
        end
    end
endmodule

// File: doc/fmi_reader.md
# fmi_reader

Read-side controller for the feature-map-input RAM. On `start` it scans a rectangular tile of pixels out of the FMI RAM in row-major order and delivers them on a valid/ready stream to the processing array. It hides the RAM's one-cycle registered read latency and absorbs downstream back-pressure with a 2-entry skid buffer. It sits between the FMI RAM read port (muxed with the DMA write side at top level) and the PE input.

## Interface
Parameters (all from `ram_pkg`, not overridable per instance):
- FMI_N_ELEM, package value, depth of the FMI RAM in pixels
- PX_W, package value, pixel width in bits
- FMI_AW, $clog2(FMI_N_ELEM), RAM address width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base  in  FMI_AW  address of tile pixel (0,0)
- n_rows  in  FMI_AW  tile height
- n_cols  in  FMI_AW  tile width
- stride  in  FMI_AW  address distance between consecutive rows
- ram_addr  out  FMI_AW  read address to FMI RAM
- ram_rd  out  1  read strobe; the top level drives RAM `write`=0 while `busy`
- ram_res  in  PX_W  RAM registered read data, valid the cycle after `ram_rd`
- px_data  out  PX_W  stream pixel
- px_valid  out  1  stream valid
- px_ready  in  1  stream ready
- px_last  out  1  qualifies the final pixel of the tile
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at tile completion

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: `start`=1 latches base, n_rows, n_cols, stride, clears row/col counters, and goes to READ. If n_rows=0 or n_cols=0, go directly to IDLE with `done` pulsed the next cycle and no `ram_rd`.
- READ: issue read at `base + row*stride + col`, computed modulo 2^FMI_AW; the address wraps silently. Incrementing is accumulative: row base += stride, col += 1. Issue only when `fifo_count + inflight - pop < 2`, where pop = px_valid & px_ready in the same cycle. After issuing (n_rows-1, n_cols-1), go to DRAIN.
- `inflight` is 1 in the cycle after `ram_rd`. In that cycle, `ram_res` is pushed into the skid FIFO. `ram_res` is ignored when `inflight`=0.
- DRAIN: no reads. When the last pixel handshakes, go to IDLE and pulse `done` in the following cycle.
- `px_last`=1 with the pixel whose index equals n_rows*n_cols-1, tracked by a pushed-pixel tag bit.
- `start` is ignored in READ and DRAIN.
- `px_data` and `px_valid` hold stable while px_valid=1 and px_ready=0.
- No pixel is dropped or duplicated under any px_ready pattern.

## Timing
- Reset values: ram_addr=0, ram_rd=0, px_data=0, px_valid=0, px_last=0, busy=0, done=0, state IDLE, FIFO empty, inflight=0.
- `start` accepted in cycle 0: busy=1 and first `ram_rd` in cycle 1, data in `ram_res` in cycle 2, px_valid=1 in cycle 3.
- With px_ready held high: one pixel per cycle. An R×C tile completes its last handshake at cycle 2+R*C, and `done` pulses at cycle 3+R*C with busy=0 in that same cycle.
- A new `start` is accepted from the cycle `done` is high onward.
- Back-pressure: at most 2 pixels are buffered plus 0 in flight. Reads resume in the cycle the first pop occurs.
- Reset asserted mid-tile: everything returns to reset values immediately. In-flight RAM data is discarded.

## Structure
- Add to `ram_pkg`:
  - FMI_AW
  - typedef `fmi_rd_state_t` enum {IDLE, READ, DRAIN}
  - typedef `px_t` = logic [PX_W-1:0]
- One sub-module `px_skid_fifo`: 2-entry FIFO of {px_t, last bit} with push, pop, count, and asynchronous active-low reset.
- Address generation and the FSM stay in `fmi_reader`.

## Test plan
- 2×3 tile, base=10, stride=8, px_ready=1 → `ram_addr` sequence 10,11,12,18,19,20 in cycles 1–6; pixels equal preloaded mem values in order; px_last on the 6th pixel; done at cycle 9.
- Same tile with px_ready=0 for cycles 4–8 → `ram_rd` stalls once 2 pixels are buffered; all 6 pixels are delivered exactly once in order; px_data is stable during the stall.
- n_rows=0, n_cols=5, start → done=1 at cycle 1; `ram_rd` never asserted; px_valid stays 0.
- base=FMI_N_ELEM-2, 1×4 tile → addresses FMI_N_ELEM-2, FMI_N_ELEM-1, 0, 1.
- start pulsed again during READ with a different base → ignored; the original tile completes unchanged.
- rst_n low during DRAIN → all outputs 0 immediately; a new 1×1 tile after release completes normally with done at cycle 4.
